// File: rtl/serial_parity_rx_if.sv
// Bit-strobe input and valid/ready word output of the serial parity receiver.
// The receiver uses the slave modport; the bit source and word consumer use master.
interface serial_parity_rx_if #(
    parameter int width_p = 8
);
    logic               bit_v_i;
    logic               bit_i;
    logic               ready_i;
    logic [width_p-1:0] data_o;
    logic               v_o;
    logic               parity_err_o;
    logic               frame_err_o;
    logic               overrun_o;
    logic               busy_o;

    modport slave (
        input  bit_v_i,
        input  bit_i,
        input  ready_i,
        output data_o,
        output v_o,
        output parity_err_o,
        output frame_err_o,
        output overrun_o,
        output busy_o
    );

    modport master (
        output bit_v_i,
        output bit_i,
        output ready_i,
        input  data_o,
        input  v_o,
        input  parity_err_o,
        input  frame_err_o,
        input  overrun_o,
        input  busy_o
    );
endinterface

// File: rtl/serial_parity_rx.sv
// Strobe-qualified serial frame receiver: start, width_p data bits LSB first,
// parity, stop. Words are held in a one-deep valid/ready slot; full-slot arrivals are dropped.
module serial_parity_rx #(
    parameter int width_p = 8,
    parameter int odd_p   = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    serial_parity_rx_if.slave     bus
);

    localparam int          cnt_w_c = (width_p > 1) ? $clog2(width_p) : 1;
    localparam logic [cnt_w_c-1:0] last_c = cnt_w_c'(width_p - 1);
    localparam logic        odd_c  = (odd_p != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    function automatic logic parity_of(input logic [width_p-1:0] word);
        return ^word;
    endfunction

    state_t               state_r;
    state_t               state_s;
    logic [cnt_w_c-1:0]   count_r;
    logic [cnt_w_c-1:0]   count_s;
    logic [width_p-1:0]   shift_r;
    logic [width_p-1:0]   shift_s;
    logic                 perr_r;
    logic                 perr_s;
    logic                 deliver_s;
    logic                 ferr_s;
    logic                 load_s;
    logic                 pop_s;

    logic [width_p-1:0]   data_r;
    logic                 v_r;
    logic                 parity_err_r;
    logic                 frame_err_r;
    logic                 overrun_r;
    logic                 busy_r;

    // Frame state machine: every transition is gated by the bit strobe.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        shift_s   = shift_r;
        perr_s    = perr_r;
        deliver_s = 1'b0;
        ferr_s    = 1'b0;
        if (bus.bit_v_i) begin
            case (state_r)
                IDLE: begin
                    if (!bus.bit_i) begin
                        state_s = DATA;
                        count_s = '0;
                    end else begin
                        state_s = IDLE;
                    end
                end
                DATA: begin
                    shift_s[count_r] = bus.bit_i;
                    if (count_r == last_c) begin
                        state_s = PARITY;
                    end else begin
                        count_s = count_r + cnt_w_c'(1);
                    end
                end
                PARITY: begin
                    // Error when data^parity disagrees with the configured sense.
                    perr_s  = parity_of(shift_r) ^ bus.bit_i ^ odd_c;
                    state_s = STOP;
                end
                STOP: begin
                    deliver_s = 1'b1;
                    ferr_s    = ~bus.bit_i;
                    state_s   = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // A finished frame may enter the slot if it is empty or being emptied this cycle.
    always_comb begin
        pop_s  = v_r & bus.ready_i;
        load_s = deliver_s & (~v_r | bus.ready_i);
    end

    // Frame state, bit counter, shift register and captured parity result.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            count_r <= '0;
            shift_r <= '0;
            perr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            shift_r <= shift_s;
            perr_r  <= perr_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Output slot: load on delivery, clear on pop, pulse overrun on a dropped frame.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_r       <= '0;
            v_r          <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            overrun_r <= deliver_s & ~load_s;
            if (load_s) begin
                data_r       <= shift_r;
                parity_err_r <= perr_r;
                frame_err_r  <= ferr_s;
                v_r          <= 1'b1;
            end else if (pop_s) begin
                v_r <= 1'b0;
            end else begin
                v_r <= v_r;
            end
        end
    end

    assign bus.data_o       = data_r;
    assign bus.v_o          = v_r;
    assign bus.parity_err_o = parity_err_r;
    assign bus.frame_err_o  = frame_err_r;
    assign bus.overrun_o    = overrun_r;
    assign bus.busy_o       = busy_r;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Scoreboard bench for serial_parity_rx: an even-parity and an odd-parity instance,
// directed frames with hand-computed words and flags.
module tb_serial_parity_rx;

    logic clk;
    logic rst;

    serial_parity_rx_if #(.width_p(8)) e_if ();
    serial_parity_rx_if #(.width_p(8)) o_if ();

    serial_parity_rx #(.width_p(8), .odd_p(0)) u_even (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (e_if.slave)
    );

    serial_parity_rx #(.width_p(8), .odd_p(1)) u_odd (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (o_if.slave)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q_even[$];
    exp_t q_odd[$];
    int   checks   = 0;
    int   errors   = 0;
    int   ovr_seen = 0;
    int   ovr_exp  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Even-instance monitor: every accepted word is compared with the queue head.
    always @(negedge clk) begin
        if (!rst && e_if.v_o && e_if.ready_i) begin
            if (q_even.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL even_unexpected: got data 0x%0h, no word expected", e_if.data_o);
            end else begin
                exp_t e;
                e = q_even.pop_front();
                chk("even_data", {24'd0, e_if.data_o}, {24'd0, e.data});
                chk("even_perr", {31'd0, e_if.parity_err_o}, {31'd0, e.perr});
                chk("even_ferr", {31'd0, e_if.frame_err_o}, {31'd0, e.ferr});
            end
        end
        if (!rst && e_if.overrun_o) ovr_seen++;
    end

    always @(negedge clk) begin
        if (!rst && o_if.v_o && o_if.ready_i) begin
            if (q_odd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL odd_unexpected: got data 0x%0h, no word expected", o_if.data_o);
            end else begin
                exp_t e;
                e = q_odd.pop_front();
                chk("odd_data", {24'd0, o_if.data_o}, {24'd0, e.data});
                chk("odd_perr", {31'd0, o_if.parity_err_o}, {31'd0, e.perr});
                chk("odd_ferr", {31'd0, o_if.frame_err_o}, {31'd0, e.ferr});
            end
        end
    end

    // One strobe, then gap idle cycles; returns 1 time unit after the last edge.
    task automatic drive_bit(input bit sel, input logic b, input int gap);
        if (sel) begin
            o_if.bit_v_i = 1'b1;
            o_if.bit_i   = b;
        end else begin
            e_if.bit_v_i = 1'b1;
            e_if.bit_i   = b;
        end
        @(posedge clk);
        #1;
        e_if.bit_v_i = 1'b0;
        o_if.bit_v_i = 1'b0;
        e_if.bit_i   = 1'b1;
        o_if.bit_i   = 1'b1;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // gap < 0 selects a random 1..5 idle cycles after every strobe but the stop bit.
    task automatic send_frame(input bit sel, input logic [7:0] d, input logic p,
                              input logic stop, input int gap, input bit rdy_on_stop);
        int g;
        g = (gap < 0) ? int'($urandom_range(1, 5)) : gap;
        drive_bit(sel, 1'b0, g);
        for (int i = 0; i < 8; i++) begin
            g = (gap < 0) ? int'($urandom_range(1, 5)) : gap;
            drive_bit(sel, d[i], g);
        end
        g = (gap < 0) ? int'($urandom_range(1, 5)) : gap;
        drive_bit(sel, p, g);
        if (rdy_on_stop) e_if.ready_i = 1'b1;
        drive_bit(sel, stop, 0);
    endtask

    initial begin
        rst          = 1'b1;
        e_if.bit_v_i = 1'b0;
        e_if.bit_i   = 1'b1;
        e_if.ready_i = 1'b1;
        o_if.bit_v_i = 1'b0;
        o_if.bit_i   = 1'b1;
        o_if.ready_i = 1'b1;
        #2;
        chk("reset_v", {31'd0, e_if.v_o}, 32'd0);
        chk("reset_busy", {31'd0, e_if.busy_o}, 32'd0);
        chk("reset_data", {24'd0, e_if.data_o}, 32'd0);
        chk("reset_overrun", {31'd0, e_if.overrun_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: 0xA5 back-to-back strobes, latency and busy window
        chk("t1_busy_idle", {31'd0, e_if.busy_o}, 32'd0);
        q_even.push_back('{8'hA5, 1'b0, 1'b0});
        drive_bit(1'b0, 1'b0, 0);
        chk("t1_busy_after_start", {31'd0, e_if.busy_o}, 32'd1);
        for (int i = 0; i < 8; i++) drive_bit(1'b0, ((8'hA5 >> i) & 8'h01) != 8'h00, 0);
        drive_bit(1'b0, 1'b0, 0);
        chk("t1_busy_before_stop", {31'd0, e_if.busy_o}, 32'd1);
        chk("t1_v_before_stop", {31'd0, e_if.v_o}, 32'd0);
        drive_bit(1'b0, 1'b1, 0);
        chk("t1_v_after_stop", {31'd0, e_if.v_o}, 32'd1);
        chk("t1_data", {24'd0, e_if.data_o}, 32'h0000_00A5);
        chk("t1_busy_after_stop", {31'd0, e_if.busy_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("t1_v_cleared", {31'd0, e_if.v_o}, 32'd0);

        // 2: parity error on even, clean and bad odd-parity words
        q_even.push_back('{8'h07, 1'b1, 1'b0});
        send_frame(1'b0, 8'h07, 1'b0, 1'b1, 0, 1'b0);
        q_odd.push_back('{8'h00, 1'b0, 1'b0});
        send_frame(1'b1, 8'h00, 1'b1, 1'b1, 0, 1'b0);
        q_odd.push_back('{8'h00, 1'b1, 1'b0});
        send_frame(1'b1, 8'h00, 1'b0, 1'b1, 1, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // 3: framing error returns to IDLE
        q_even.push_back('{8'h3C, 1'b0, 1'b1});
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 0, 1'b0);
        chk("t3_busy", {31'd0, e_if.busy_o}, 32'd0);
        chk("t3_ferr", {31'd0, e_if.frame_err_o}, 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // 4: stalled consumer drops the second frame
        e_if.ready_i = 1'b0;
        q_even.push_back('{8'h11, 1'b0, 1'b0});
        send_frame(1'b0, 8'h11, 1'b0, 1'b1, 0, 1'b0);
        ovr_exp++;
        send_frame(1'b0, 8'h22, 1'b0, 1'b1, 0, 1'b0);
        chk("t4_overrun", {31'd0, e_if.overrun_o}, 32'd1);
        chk("t4_v_held", {31'd0, e_if.v_o}, 32'd1);
        chk("t4_data_held", {24'd0, e_if.data_o}, 32'h0000_0011);
        @(posedge clk);
        #1;
        chk("t4_overrun_pulse", {31'd0, e_if.overrun_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        e_if.ready_i = 1'b1;
        @(posedge clk);
        #1;
        e_if.ready_i = 1'b0;
        chk("t4_v_after_pop", {31'd0, e_if.v_o}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_no_stale_word", {31'd0, e_if.v_o}, 32'd0);

        // 5: pop and load on the same edge
        q_even.push_back('{8'h33, 1'b0, 1'b0});
        q_even.push_back('{8'h44, 1'b0, 1'b0});
        send_frame(1'b0, 8'h33, 1'b0, 1'b1, 0, 1'b0);
        send_frame(1'b0, 8'h44, 1'b0, 1'b1, 0, 1'b1);
        chk("t5_v_kept", {31'd0, e_if.v_o}, 32'd1);
        chk("t5_data_new", {24'd0, e_if.data_o}, 32'h0000_0044);
        chk("t5_no_overrun", {31'd0, e_if.overrun_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // 6a: asynchronous reset mid-frame
        drive_bit(1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b1, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", {31'd0, e_if.busy_o}, 32'd0);
        chk("t6_rst_v", {31'd0, e_if.v_o}, 32'd0);
        chk("t6_rst_data", {24'd0, e_if.data_o}, 32'd0);
        e_if.bit_v_i = 1'b1;
        e_if.bit_i   = 1'b0;
        @(posedge clk);
        #1;
        e_if.bit_v_i = 1'b0;
        e_if.bit_i   = 1'b1;
        rst = 1'b0;
        chk("t6_busy_after_rst", {31'd0, e_if.busy_o}, 32'd0);
        q_even.push_back('{8'h5A, 1'b0, 1'b0});
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // 6b: spaced strobes after idle-high strobes
        for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'b1, 1);
        chk("t6_idle_busy", {31'd0, e_if.busy_o}, 32'd0);
        q_even.push_back('{8'h81, 1'b0, 1'b0});
        send_frame(1'b0, 8'h81, 1'b0, 1'b1, -1, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        chk("even_queue_drained", q_even.size(), 32'd0);
        chk("odd_queue_drained", q_odd.size(), 32'd0);
        chk("overrun_count", ovr_seen, ovr_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
